// File: rtl/system.sv
// system: single-bus 32-bit CPU datapath with register file, ALU, special registers and 512x32 memory.
module system #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  Clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] inport_data,
  input  logic                  inport_data_ready,
  output logic [DATA_WIDTH-1:0] outport_data,
  input  logic                  HIout,
  input  logic                  LOout,
  input  logic                  Zhi_out,
  input  logic                  Zlo_out,
  input  logic                  PCout,
  input  logic                  MDRout,
  input  logic                  Inport_out,
  input  logic                  Cout,
  input  logic                  MARin,
  input  logic                  Zin,
  input  logic                  PCin,
  input  logic                  MDRin,
  input  logic                  IRin,
  input  logic                  Yin,
  input  logic                  HIin,
  input  logic                  LOin,
  input  logic                  outport_in,
  input  logic [4:0]            opcode,
  input  logic                  IncPC,
  input  logic                  Gra,
  input  logic                  Grb,
  input  logic                  Grc,
  input  logic                  Rin,
  input  logic                  Rout,
  input  logic                  BAout,
  output logic                  con_ff_bit,
  input  logic                  Mem_Read,
  input  logic                  Mem_Write,
  input  logic                  Mem_enable512x32,
  output logic [DATA_WIDTH-1:0] Mem_to_datapath_out,
  output logic [DATA_WIDTH-1:0] Mem_data_to_chip_out,
  output logic [ADDR_WIDTH-1:0] MAR_address_out,
  input  logic                  mem_overide,
  input  logic [ADDR_WIDTH-1:0] overide_address,
  input  logic [DATA_WIDTH-1:0] overide_data_in
);
  localparam int W = DATA_WIDTH;
  logic [W-1:0] r [16];
  logic [W-1:0] pc, mdr, y, hi, lo, inport, outport;
  logic [26:0] ir;
  logic [2*W-1:0] z, alu;
  logic [ADDR_WIDTH-1:0] mar;
  logic con, cond;
  logic [3:0] sel;
  logic [W-1:0] bus, c_ext, reg_out, alu_lo;
  logic [4:0] sh;
  logic [W-1:0] mem [2**ADDR_WIDTH];
  logic mem_clk, mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [W-1:0] mem_din;
  assign sel = ({4{Gra}} & ir[26:23]) | ({4{Grb}} & ir[22:19]) | ({4{Grc}} & ir[18:15]);
  assign c_ext = {{(W-19){ir[18]}}, ir[18:0]};
  assign reg_out = (BAout && sel == 4'd0) ? '0 : r[sel];
  assign bus = (Rout || BAout) ? reg_out : PCout ? pc : MDRout ? mdr : Zhi_out ? z[2*W-1:W] :
               Zlo_out ? z[W-1:0] : HIout ? hi : LOout ? lo : Inport_out ? inport :
               Cout ? c_ext : '0;
  assign sh = bus[4:0];
  always_comb begin
    alu_lo = '0;
    case (opcode)
      5'b00011: alu_lo = y + bus;
      5'b00100: alu_lo = y - bus;
      5'b00101: alu_lo = y >> sh;
      5'b00110: alu_lo = $signed(y) >>> sh;
      5'b00111: alu_lo = y << sh;
      5'b01000: alu_lo = W'({y, y} >> sh);
      5'b01001: alu_lo = ({y, y} << sh) >> W;
      5'b01010: alu_lo = y | bus;
      5'b01011: alu_lo = y & bus;
      5'b10001: alu_lo = -bus;
      5'b10010: alu_lo = ~bus;
      default:  alu_lo = '0;
    endcase
  end
  assign alu = {{W{1'b0}}, IncPC ? bus + W'(1) : alu_lo};
  assign cond = ir[20:19] == 2'b00 ? bus == '0 : ir[20:19] == 2'b01 ? bus != '0 :
                ir[20:19] == 2'b10 ? (!bus[W-1] && bus != '0) : bus[W-1];
  // Backdoor preload is clocked by the enable strobe, so the memory clock is muxed with it.
  assign mem_clk = mem_overide ? Mem_enable512x32 : Clock;
  assign mem_we = mem_overide | (Mem_enable512x32 & Mem_Write);
  assign mem_addr = mem_overide ? overide_address : mar;
  assign mem_din = mem_overide ? overide_data_in : mdr;
  always_ff @(posedge mem_clk)
    if (mem_we) mem[mem_addr] <= mem_din;
  assign Mem_to_datapath_out = (Mem_enable512x32 && Mem_Read && !mem_overide) ? mem[mar] : '0;
  assign Mem_data_to_chip_out = mem_overide ? overide_data_in : mdr;
  assign MAR_address_out = mar;
  assign outport_data = outport;
  assign con_ff_bit = con;
  always_ff @(posedge Clock) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) r[i] <= '0;
      pc <= '0;
      ir <= '0;
      mar <= '0;
      mdr <= '0;
      y <= '0;
      z <= '0;
      hi <= '0;
      lo <= '0;
      inport <= '0;
      outport <= '0;
      con <= 1'b0;
    end else begin
      if (Rin) r[sel] <= bus;
      if (PCin) pc <= bus;
      if (IRin) ir <= bus[26:0];
      if (MARin) mar <= bus[ADDR_WIDTH-1:0];
      if (MDRin) mdr <= Mem_Read ? Mem_to_datapath_out : bus;
      if (Yin) y <= bus;
      if (Zin) z <= alu;
      if (HIin) hi <= bus;
      if (LOin) lo <= bus;
      if (inport_data_ready) inport <= inport_data;
      if (outport_in) outport <= bus;
      if (Gra && Rout) con <= cond;
    end
  end
endmodule

// File: tb/tb_system.sv
// tb_system: directed bench for the datapath with an operation-level architectural model.
module tb_system;
  logic Clock = 1'b0, clear;
  logic [31:0] inport_data, outport_data, Mem_to_datapath_out, Mem_data_to_chip_out, overide_data_in;
  logic inport_data_ready, HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, outport_in;
  logic [4:0] opcode;
  logic IncPC, Gra, Grb, Grc, Rin, Rout, BAout, con_ff_bit;
  logic Mem_Read, Mem_Write, Mem_enable512x32, mem_overide;
  logic [8:0] MAR_address_out, overide_address;
  system dut (
    .Clock(Clock), .clear(clear), .inport_data(inport_data), .inport_data_ready(inport_data_ready),
    .outport_data(outport_data), .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
    .PCout(PCout), .MDRout(MDRout), .Inport_out(Inport_out), .Cout(Cout), .MARin(MARin), .Zin(Zin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
    .outport_in(outport_in), .opcode(opcode), .IncPC(IncPC), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .con_ff_bit(con_ff_bit), .Mem_Read(Mem_Read),
    .Mem_Write(Mem_Write), .Mem_enable512x32(Mem_enable512x32),
    .Mem_to_datapath_out(Mem_to_datapath_out), .Mem_data_to_chip_out(Mem_data_to_chip_out),
    .MAR_address_out(MAR_address_out), .mem_overide(mem_overide),
    .overide_address(overide_address), .overide_data_in(overide_data_in)
  );
  always #5 Clock = ~Clock;
  int vectors = 0, errors = 0;
  logic live = 1'b0;
  logic [31:0] m_r [16];
  logic [31:0] m_mem [512];
  logic [31:0] m_pc, m_ir, m_mdr, m_y, m_zlo, m_hi, m_lo, m_in, m_out, tmp;
  logic [8:0] m_mar;
  logic m_con;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res;
    int s;
    s = int'(b[4:0]);
    res = 32'h0;
    case (op)
      5'd3: res = a + b;
      5'd4: res = a - b;
      5'd5: res = a >> s;
      5'd6: res = $signed(a) >>> s;
      5'd7: res = a << s;
      5'd8: for (int i = 0; i < 32; i++) res[i] = a[(i + s) % 32];
      5'd9: for (int i = 0; i < 32; i++) res[(i + s) % 32] = a[i];
      5'd10: res = a | b;
      5'd11: res = a & b;
      5'd17: res = 32'h0 - b;
      5'd18: res = ~b;
      default: res = 32'h0;
    endcase
    return res;
  endfunction
  function automatic logic cond_f(input logic [1:0] c2, input logic [31:0] v);
    return c2 == 2'd0 ? v == 0 : c2 == 2'd1 ? v != 0 : c2 == 2'd2 ? $signed(v) > 0 : $signed(v) < 0;
  endfunction
  always @(negedge Clock) if (live) begin
    check("outport", outport_data, m_out);
    check("con", {31'b0, con_ff_bit}, {31'b0, m_con});
    check("mar", {23'b0, MAR_address_out}, {23'b0, m_mar});
    check("chip_out", Mem_data_to_chip_out, mem_overide ? overide_data_in : m_mdr);
    check("mem_rd", Mem_to_datapath_out,
          (Mem_enable512x32 && Mem_Read && !mem_overide) ? m_mem[m_mar] : 32'h0);
  end
  task automatic idle();
    {clear, inport_data_ready, HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, outport_in, IncPC} = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout, Mem_Read, Mem_Write, Mem_enable512x32} = '0;
    opcode = 5'd0;
  endtask
  task automatic cyc();
    @(posedge Clock);
    #1 idle();
  endtask
  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_r[i] = 0;
    {m_pc, m_ir, m_mdr, m_y, m_zlo, m_hi, m_lo, m_in, m_out} = '0;
    m_mar = 0;
    m_con = 0;
  endtask
  task automatic do_clear();
    clear = 1; cyc(); m_reset();
  endtask
  task automatic bus_in(input logic [31:0] v);
    inport_data = v; inport_data_ready = 1; cyc(); m_in = v;
  endtask
  task automatic set_mar(input logic [8:0] a);
    bus_in({23'b0, a});
    Inport_out = 1; MARin = 1; cyc(); m_mar = a;
  endtask
  task automatic mem_read();
    Mem_Read = 1; Mem_enable512x32 = 1; MDRin = 1; cyc(); m_mdr = m_mem[m_mar];
  endtask
  task automatic bd(input logic [8:0] a, input logic [31:0] d);
    overide_address = a; overide_data_in = d;
    #2 Mem_enable512x32 = 1;
    #3 Mem_enable512x32 = 0;
    @(posedge Clock);
    #1 m_mem[a] = d;
  endtask
  task automatic fetch();
    PCout = 1; IncPC = 1; MARin = 1; Zin = 1; cyc(); m_mar = m_pc[8:0]; m_zlo = m_pc + 1;
    Zlo_out = 1; PCin = 1; MDRin = 1; Mem_Read = 1; Mem_enable512x32 = 1; cyc();
    m_pc = m_zlo; m_mdr = m_mem[m_mar];
    MDRout = 1; IRin = 1; cyc(); m_ir = m_mdr;
  endtask
  task automatic imm();
    Grb = 1; Rout = 1; Yin = 1; cyc(); m_y = m_r[m_ir[22:19]];
    opcode = m_ir[31:27]; Cout = 1; Zin = 1; cyc();
    m_zlo = alu_f(m_ir[31:27], m_y, {{13{m_ir[18]}}, m_ir[18:0]});
    Zlo_out = 1; Gra = 1; Rin = 1; cyc(); m_r[m_ir[26:23]] = m_zlo;
  endtask
  task automatic show_ra();
    Gra = 1; Rout = 1; outport_in = 1; cyc();
    m_out = m_r[m_ir[26:23]]; m_con = cond_f(m_ir[20:19], m_out);
  endtask
  task automatic show_pc();
    PCout = 1; outport_in = 1; cyc(); m_out = m_pc;
  endtask
  task automatic alu_test(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e, input string n);
    bus_in(a);
    Inport_out = 1; Yin = 1; inport_data = b; inport_data_ready = 1; cyc(); m_y = a; m_in = b;
    opcode = op; Inport_out = 1; Zin = 1; cyc(); m_zlo = alu_f(op, m_y, m_in);
    Zlo_out = 1; outport_in = 1; cyc(); m_out = m_zlo;
    check(n, outport_data, e);
  endtask
  logic [8:0] pre_a [5] = '{9'd0, 9'd1, 9'd2, 9'd500, 9'd501};
  logic [31:0] pre_d [5] = '{32'h18900001, 32'h58900003, 32'h50900009, 32'h14, 32'h14};
  logic [31:0] exp_r [3] = '{32'd1, 32'd0, 32'd9};
  logic [31:0] exp_c [3] = '{32'd1, 32'd0, 32'd1};
  initial begin
    for (int i = 0; i < 512; i++) m_mem[i] = 0;
    idle();
    mem_overide = 0; inport_data = 0; overide_address = 0; overide_data_in = 0;
    @(posedge Clock);
    #1 do_clear();
    live = 1;
    check("rst_outport", outport_data, 32'h0);
    check("rst_con", {31'b0, con_ff_bit}, 32'h0);
    check("rst_mar", {23'b0, MAR_address_out}, 32'h0);
    mem_overide = 1;
    for (int i = 0; i < 5; i++) bd(pre_a[i], pre_d[i]);
    mem_overide = 0;
    for (int i = 0; i < 5; i++) begin
      set_mar(pre_a[i]);
      mem_read();
      check($sformatf("readback_%0d", pre_a[i]), Mem_data_to_chip_out, pre_d[i]);
    end
    do_clear();
    for (int i = 0; i < 3; i++) begin
      fetch();
      imm();
      show_ra();
      check($sformatf("prog_r1_%0d", i), outport_data, exp_r[i]);
      check($sformatf("prog_con_%0d", i), {31'b0, con_ff_bit}, exp_c[i]);
      show_pc();
      check($sformatf("prog_pc_%0d", i), outport_data, i + 1);
    end
    alu_test(5'd4, 32'h0, 32'h1, 32'hFFFFFFFF, "sub_0_1");
    alu_test(5'd3, 32'hFFFFFFFF, 32'h1, 32'h0, "add_wrap");
    alu_test(5'd6, 32'h80000000, 32'd4, 32'hF8000000, "shra");
    alu_test(5'd5, 32'h80000000, 32'd4, 32'h08000000, "shr");
    alu_test(5'd7, 32'h1, 32'd31, 32'h80000000, "shl");
    alu_test(5'd8, 32'h1, 32'd1, 32'h80000000, "ror");
    alu_test(5'd9, 32'h80000001, 32'd1, 32'h3, "rol");
    alu_test(5'd10, 32'hF0F00000, 32'h0000FF00, 32'hF0F0FF00, "or");
    alu_test(5'd11, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, "and");
    alu_test(5'd17, 32'h0, 32'd5, 32'hFFFFFFFB, "neg");
    alu_test(5'd18, 32'h0, 32'h0F0F0F0F, 32'hF0F0F0F0, "not");
    alu_test(5'd31, 32'h5, 32'h7, 32'h0, "bad_op");
    Zhi_out = 1; outport_in = 1; cyc(); m_out = 0;
    check("zhi_zero", outport_data, 32'h0);
    bus_in(32'h12345678);
    Inport_out = 1; HIin = 1; inport_data = 32'h9ABCDEF0; inport_data_ready = 1; cyc();
    m_hi = m_in; m_in = 32'h9ABCDEF0;
    Inport_out = 1; LOin = 1; cyc(); m_lo = m_in;
    HIout = 1; outport_in = 1; cyc(); m_out = m_hi;
    check("hi", outport_data, 32'h12345678);
    LOout = 1; outport_in = 1; cyc(); m_out = m_lo;
    check("lo", outport_data, 32'h9ABCDEF0);
    set_mar(9'd500);
    bus_in(32'hDEADBEEF);
    Inport_out = 1; MDRin = 1; cyc(); m_mdr = m_in;
    Mem_Write = 1; Mem_enable512x32 = 1; cyc(); m_mem[m_mar] = m_mdr;
    bus_in(32'h0);
    Inport_out = 1; MDRin = 1; cyc(); m_mdr = 0;
    mem_read();
    check("write_read", Mem_data_to_chip_out, 32'hDEADBEEF);
    set_mar(9'd501);
    Inport_out = 1; bus_in(32'hCAFEF00D);
    Inport_out = 1; MDRin = 1; cyc(); m_mdr = m_in;
    Mem_Write = 1; Mem_Read = 1; MDRin = 1; Mem_enable512x32 = 1; cyc();
    tmp = m_mem[m_mar]; m_mem[m_mar] = m_mdr; m_mdr = tmp;
    check("rw_same_old", Mem_data_to_chip_out, 32'h14);
    mem_read();
    check("rw_same_new", Mem_data_to_chip_out, 32'hCAFEF00D);
    do_clear();
    bus_in(32'd5);
    Inport_out = 1; Gra = 1; Rin = 1; cyc(); m_r[0] = m_in;
    show_ra();
    check("r0_rout", outport_data, 32'd5);
    Gra = 1; BAout = 1; outport_in = 1; cyc(); m_out = 0;
    check("r0_baout", outport_data, 32'd0);
    do_clear();
    fetch();
    Grb = 1; Rout = 1; Yin = 1; cyc(); m_y = m_r[m_ir[22:19]];
    opcode = m_ir[31:27]; Cout = 1; Zin = 1; outport_in = 1; clear = 1; cyc(); m_reset();
    check("mid_outport", outport_data, 32'h0);
    check("mid_mar", {23'b0, MAR_address_out}, 32'h0);
    check("mid_mdr", Mem_data_to_chip_out, 32'h0);
    Zlo_out = 1; outport_in = 1; cyc(); m_out = m_zlo;
    check("mid_z", outport_data, 32'h0);
    show_pc();
    check("mid_pc", outport_data, 32'h0);
    set_mar(9'd0);
    mem_read();
    check("mid_mem0", Mem_data_to_chip_out, 32'h18900001);
    set_mar(9'd500);
    mem_read();
    check("mid_mem500", Mem_data_to_chip_out, 32'hDEADBEEF);
    cyc();
    live = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/system.md
# system

Single-bus 32-bit CPU datapath with an integrated 512×32 memory, driven cycle-by-cycle by externally supplied control signals (no internal control unit). It contains:

- a general register file,
- special registers, an ALU and bus,
- memory, plus a backdoor port for preloading it.

It is the top of the processor datapath; a control unit or bench sequences it through fetch/execute T-states.

## Interface
- DATA_WIDTH, 32, datapath/bus/memory word width
- ADDR_WIDTH, 9, memory address width (512 words)

Ports (control inputs are 1 bit unless stated):
- Clock  in  1  single system clock; all registers update on rising edge
- clear  in  1  reset, synchronous and active-high
- inport_data  in  32  external input-port data
- inport_data_ready  in  1  input-port register loads inport_data
- outport_data  out  32  output-port register contents
- HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout  in  1 each  bus drive selects
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, outport_in  in  1 each  register load enables
- opcode  in  5  ALU operation select
- IncPC  in  1  ALU forced to bus+1
- Gra, Grb, Grc  in  1 each  select IR field Ra/Rb/Rc as the active register
- Rin  in  1  write the active register from the bus
- Rout  in  1  drive the active register onto the bus
- BAout  in  1  same as Rout, but R0 reads as 0
- con_ff_bit  out  1  branch-condition flip-flop
- Mem_Read, Mem_Write, Mem_enable512x32  in  1 each  memory controls
- Mem_to_datapath_out  out  32  memory read data
- Mem_data_to_chip_out  out  32  memory write data
- MAR_address_out  out  ADDR_WIDTH  current memory address
- mem_overide  in  1  backdoor memory-load mode
- overide_address  in  ADDR_WIDTH  backdoor address
- overide_data_in  in  32  backdoor data

## Operation
- **Instruction fields:**
  - IR[31:27] opcode
  - Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15]
  - C = IR[18:0], sign-extended to 32 bits
  - C2 = IR[20:19]
- **Register file:** R0–R15, 32 bits. The active register is the OR of the fields selected by Gra/Grb/Grc.
- **Bus:** combinational. Out-driver priority is Rout/BAout > PCout > MDRout > Zhi_out > Zlo_out > HIout > LOout > Inport_out > Cout. With no driver the bus is 0. Cout drives the sign-extended C.
- **Y register** loads from the bus. The ALU computes A=Y, B=bus and produces a 64-bit result that loads into Z on Zin.
- **ALU opcodes** (Zhi = 0 unless noted):
  - 00011 ADD, 00100 SUB
  - 00101 SHR, 00110 SHRA, 00111 SHL, 01000 ROR, 01001 ROL (shift amount B[4:0])
  - 01010 OR, 01011 AND
  - 10001 NEG(B), 10010 NOT(B)
  - any other opcode: Z = 0
  - IncPC=1 overrides opcode: Z = {0, B+1}
- **Arithmetic** is 32-bit wrap-around.
- **Loads:** PC, IR, HI, LO and the outport register load from the bus. MAR loads bus[ADDR_WIDTH-1:0].
- **MDR** loads the memory read data when Mem_Read=1, otherwise the bus.
- **Memory reads:** asynchronous. Mem_to_datapath_out = mem[MAR] when Mem_enable512x32 & Mem_Read, else 0.
- **Memory writes:** on the Clock edge when Mem_enable512x32 & Mem_Write & !mem_overide, mem[MAR] <= MDR.
- **Backdoor:** while mem_overide=1, each rising edge of Mem_enable512x32 writes overide_data_in to mem[overide_address]. This is a preload path only, independent of Clock. Normal reads and writes are blocked during it.
- **Memory outputs:** Mem_data_to_chip_out = overide_data_in when mem_overide=1, else MDR. MAR_address_out = MAR.
- **CON FF:** loads on Clock when (Gra & Rout). It evaluates the bus against C2:
  - 00 → 1 if bus == 0
  - 01 → 1 if bus ≠ 0
  - 10 → 1 if bus is positive
  - 11 → 1 if bus is negative

## Timing
- Every register load takes effect on the rising Clock edge where its enable is high. Results are visible on the bus in the next cycle.
- **Reset:** clear=1 at an edge zeroes R0–R15, PC, IR, MAR, MDR, Y, Z, HI, LO, inport, outport and CON FF.
  - outport_data=0, con_ff_bit=0, MAR_address_out=0 after reset.
  - Memory contents are unaffected.
  - clear overrides all simultaneous loads, including mid-instruction.
- **Read timing:** memory read completes in one cycle. MAR loaded at Tn allows MDRin+Mem_Read at Tn+1, and MDR is valid at Tn+2.
- **Fetch sequence:**
  - T0: PCout, IncPC, MARin, Zin
  - T1: Zlo_out, PCin, MDRin, Mem_Read, Mem_enable512x32
  - T2: MDRout, IRin
- **Immediate ops:**
  - T3: Grb, Rout, Yin
  - T4: Cout, Zin, opcode
  - T5: Zlo_out, Gra, Rin
- **Simultaneous events:**
  - A register may drive the bus and load in the same cycle; it captures the old-bus value.
  - A write and a read of the same address in one cycle return the old data.

## Test plan
- **Preload and read back:** backdoor preload mem[0]=0x18900001, mem[1]=0x58900003, mem[2]=0x50900009, mem[500]=mem[501]=0x14 → read back through MAR/MDR returns identical words.
- **Immediate program:** from reset, run the fetch plus T3–T5 sequence for three instructions:
  - addi r1,r2,1 → R1=1, PC=1
  - andi r1,r2,3 → R1=0, PC=2
  - ori r1,r2,9 → R1=9, PC=3
- **SUB and boundaries:**
  - SUB with Y=0, bus=1 → Zlo=0xFFFFFFFF
  - ADD 0xFFFFFFFF+1 → Zlo=0
  - SHRA of 0x80000000 by 4 → 0xF8000000
- **Write then read:** Mem_Write with MAR=500, MDR=0xDEADBEEF → a later read gives 0xDEADBEEF.
- **BAout on R0:** R0 loaded with 5 → Rout reads 5, BAout reads 0.
- **Reset mid-instruction:** assert clear at T4 → all registers 0, outport_data=0, memory preserved.
